frame_length_monitor: RTL and testbench

//  Sits directly downstream of the frame SOP/EOP stage and consumes its valid/sop/eop outputs.

---
 rtl/frame_length_monitor.sv | 107 ++++++++++
 tb/tb_frame_length_monitor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/frame_length_monitor.sv
// Frame boundary tracker: counts valid beats per frame, reports good frame lengths,
// keeps a completed-frame count and pulses on SOP/EOP protocol violations.
module frame_length_monitor #(
   parameter int MAX_LEN = 1500,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 16
) (
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic             i_validIn,
   input  logic             i_sopIn,
   input  logic             i_eopIn,
   output logic             o_inFrame,
   output logic             o_lenValid,
   output logic [LEN_W-1:0] o_len,
   output logic [CNT_W-1:0] o_frameCount,
   output logic             o_errEopNoSop,
   output logic             o_errSopInFrame,
   output logic             o_errTooLong
);

   typedef enum logic [1:0] {IDLE, INFRAME, DISCARD} state_t;

   // One bit wider than the counter so MAX_LEN+1 is always representable.
   localparam logic [LEN_W:0] MAX_NEXT = (LEN_W + 1)'(MAX_LEN);

   state_t           state, stateNxt;
   logic [LEN_W-1:0] cnt, cntNxt;
   logic [LEN_W:0]   nextCnt;
   logic [LEN_W-1:0] lenNxt;
   logic [CNT_W-1:0] frameCountNxt;
   logic             lenValidNxt, errEopNxt, errSopNxt, errLongNxt;

   assign nextCnt   = {1'b0, cnt} + 1'b1;
   assign o_inFrame = (state != IDLE);

   always_comb begin
      stateNxt      = state;
      cntNxt        = cnt;
      lenNxt        = o_len;
      frameCountNxt = o_frameCount;
      lenValidNxt   = 1'b0;
      errEopNxt     = 1'b0;
      errSopNxt     = 1'b0;
      errLongNxt    = 1'b0;
      if (i_validIn) begin
         if (i_sopIn) begin
            // A SOP always starts a fresh frame, abandoning whatever was open.
            errSopNxt = (state != IDLE);
            if (i_eopIn) begin
               lenNxt        = LEN_W'(1);
               lenValidNxt   = 1'b1;
               frameCountNxt = o_frameCount + 1'b1;
               stateNxt      = IDLE;
               cntNxt        = '0;
            end else begin
               stateNxt = INFRAME;
               cntNxt   = LEN_W'(1);
            end
         end else begin
            unique case (state)
               IDLE: errEopNxt = i_eopIn;
               INFRAME: begin
                  if (nextCnt > MAX_NEXT) begin
                     errLongNxt = 1'b1;
                     stateNxt   = i_eopIn ? IDLE : DISCARD;
                     cntNxt     = '0;
                  end else if (i_eopIn) begin
                     lenNxt        = nextCnt[LEN_W-1:0];
                     lenValidNxt   = 1'b1;
                     frameCountNxt = o_frameCount + 1'b1;
                     stateNxt      = IDLE;
                     cntNxt        = '0;
                  end else begin
                     cntNxt = nextCnt[LEN_W-1:0];
                  end
               end
               DISCARD: if (i_eopIn) stateNxt = IDLE;
               default: stateNxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         state           <= IDLE;
         cnt             <= '0;
         o_len           <= '0;
         o_lenValid      <= 1'b0;
         o_frameCount    <= '0;
         o_errEopNoSop   <= 1'b0;
         o_errSopInFrame <= 1'b0;
         o_errTooLong    <= 1'b0;
      end else begin
         state           <= stateNxt;
         cnt             <= cntNxt;
         o_len           <= lenNxt;
         o_lenValid      <= lenValidNxt;
         o_frameCount    <= frameCountNxt;
         o_errEopNoSop   <= errEopNxt;
         o_errSopInFrame <= errSopNxt;
         o_errTooLong    <= errLongNxt;
      end
   end

endmodule

// File: tb/tb_frame_length_monitor.sv
// Directed bench for frame_length_monitor: a default-size instance plus a MAX_LEN=4,
// CNT_W=2 instance (shared stimulus) for length-limit and count-wrap scenarios.
module tb_frame_length_monitor;
   logic clk = 1'b0;
   logic arst;
   logic vld, sop, eop;

   logic        inF, lenV, eEop, eSop, eLong;
   logic [10:0] len;
   logic [15:0] fc;
   logic        inF4, lenV4, eEop4, eSop4, eLong4;
   logic [2:0]  len4;
   logic [1:0]  fc4;

   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   frame_length_monitor dut (
      .i_clk(clk), .i_arst(arst), .i_validIn(vld), .i_sopIn(sop), .i_eopIn(eop),
      .o_inFrame(inF), .o_lenValid(lenV), .o_len(len), .o_frameCount(fc),
      .o_errEopNoSop(eEop), .o_errSopInFrame(eSop), .o_errTooLong(eLong));

   frame_length_monitor #(.MAX_LEN(4), .CNT_W(2)) dut4 (
      .i_clk(clk), .i_arst(arst), .i_validIn(vld), .i_sopIn(sop), .i_eopIn(eop),
      .o_inFrame(inF4), .o_lenValid(lenV4), .o_len(len4), .o_frameCount(fc4),
      .o_errEopNoSop(eEop4), .o_errSopInFrame(eSop4), .o_errTooLong(eLong4));

   // Drive one cycle at negedge; return 1 time unit after the capturing posedge.
   task automatic beat(input logic v, input logic s, input logic e);
      @(negedge clk);
      vld = v; sop = s; eop = e;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      vld = 0; sop = 0; eop = 0; arst = 0;
      repeat (2) @(negedge clk);
      arst = 1;
   endtask

   task automatic test_reset();
      vld = 0; sop = 0; eop = 0; arst = 0;
      #12;
      nChecks++; if ({inF, lenV, len, fc, eEop, eSop, eLong} !== '0) begin nFail++; $display("FAIL reset_outs got inF=%b lenV=%b len=%0d fc=%0d errs=%b%b%b want all 0", inF, lenV, len, fc, eEop, eSop, eLong); end
      nChecks++; if ({inF4, lenV4, len4, fc4, eEop4, eSop4, eLong4} !== '0) begin nFail++; $display("FAIL reset_outs4 got nonzero outputs want all 0"); end
      arst = 1;
   endtask

   task automatic test_basic_frame();
      doReset();
      beat(1, 1, 0);
      nChecks++; if (inF !== 1'b1 || lenV !== 1'b0) begin nFail++; $display("FAIL basic_sop got inF=%b lenV=%b want 1 0", inF, lenV); end
      repeat (3) beat(1, 0, 0);
      beat(1, 0, 1);
      nChecks++; if (lenV !== 1'b1 || len !== 11'd5) begin nFail++; $display("FAIL basic_len got lenV=%b len=%0d want 1 5", lenV, len); end
      nChecks++; if (fc !== 16'd1 || inF !== 1'b0) begin nFail++; $display("FAIL basic_count got fc=%0d inF=%b want 1 0", fc, inF); end
      beat(0, 0, 0);
      nChecks++; if (lenV !== 1'b0 || len !== 11'd5) begin nFail++; $display("FAIL basic_hold got lenV=%b len=%0d want 0 5", lenV, len); end
   endtask

   task automatic test_single_beat();
      doReset();
      beat(1, 1, 1);
      nChecks++; if (lenV !== 1'b1 || len !== 11'd1 || fc !== 16'd1) begin nFail++; $display("FAIL single got lenV=%b len=%0d fc=%0d want 1 1 1", lenV, len, fc); end
      nChecks++; if (inF !== 1'b0) begin nFail++; $display("FAIL single_inframe got %b want 0", inF); end
   endtask

   task automatic test_eop_no_sop();
      doReset();
      beat(1, 0, 1);
      nChecks++; if (eEop !== 1'b1 || fc !== 16'd0 || lenV !== 1'b0) begin nFail++; $display("FAIL eopnosop got err=%b fc=%0d lenV=%b want 1 0 0", eEop, fc, lenV); end
      beat(0, 0, 0);
      nChecks++; if (eEop !== 1'b0) begin nFail++; $display("FAIL eopnosop_pulse got %b want 0", eEop); end
   endtask

   task automatic test_sop_in_frame();
      doReset();
      beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0);
      beat(1, 1, 0);
      nChecks++; if (eSop !== 1'b1 || lenV !== 1'b0 || inF !== 1'b1) begin nFail++; $display("FAIL sopinframe got err=%b lenV=%b inF=%b want 1 0 1", eSop, lenV, inF); end
      beat(1, 0, 1);
      nChecks++; if (lenV !== 1'b1 || len !== 11'd2 || fc !== 16'd1 || eSop !== 1'b0) begin nFail++; $display("FAIL sopinframe_len got lenV=%b len=%0d fc=%0d err=%b want 1 2 1 0", lenV, len, fc, eSop); end
      // SOP+EOP inside a frame: error plus a single-beat frame, nothing else.
      beat(1, 1, 0); beat(1, 1, 1);
      nChecks++; if (eSop !== 1'b1 || lenV !== 1'b1 || len !== 11'd1 || fc !== 16'd2 || eLong !== 1'b0 || eEop !== 1'b0) begin nFail++; $display("FAIL sopeop_inframe got eSop=%b lenV=%b len=%0d fc=%0d want 1 1 1 2", eSop, lenV, len, fc); end
   endtask

   task automatic test_too_long();
      doReset();
      beat(1, 1, 0); repeat (3) beat(1, 0, 0);
      beat(1, 0, 0);
      nChecks++; if (eLong4 !== 1'b1 || inF4 !== 1'b1) begin nFail++; $display("FAIL toolong got err=%b inF=%b want 1 1", eLong4, inF4); end
      beat(1, 0, 0);
      nChecks++; if (eLong4 !== 1'b0) begin nFail++; $display("FAIL toolong_once got %b want 0", eLong4); end
      beat(1, 0, 1);
      nChecks++; if (lenV4 !== 1'b0 || inF4 !== 1'b0 || fc4 !== 2'd0) begin nFail++; $display("FAIL discard_eop got lenV=%b inF=%b fc=%0d want 0 0 0", lenV4, inF4, fc4); end
      beat(1, 1, 0); beat(1, 0, 1);
      nChecks++; if (lenV4 !== 1'b1 || len4 !== 3'd2 || fc4 !== 2'd1) begin nFail++; $display("FAIL after_long got lenV=%b len=%0d fc=%0d want 1 2 1", lenV4, len4, fc4); end
      // Exactly MAX_LEN beats is legal.
      beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 1);
      nChecks++; if (lenV4 !== 1'b1 || len4 !== 3'd4 || fc4 !== 2'd2 || eLong4 !== 1'b0) begin nFail++; $display("FAIL maxlen got lenV=%b len=%0d fc=%0d err=%b want 1 4 2 0", lenV4, len4, fc4, eLong4); end
      // Overflow on the EOP beat itself: straight back to IDLE, no report.
      beat(1, 1, 0); repeat (3) beat(1, 0, 0); beat(1, 0, 1);
      nChecks++; if (eLong4 !== 1'b1 || lenV4 !== 1'b0 || inF4 !== 1'b0 || fc4 !== 2'd2) begin nFail++; $display("FAIL long_on_eop got err=%b lenV=%b inF=%b fc=%0d want 1 0 0 2", eLong4, lenV4, inF4, fc4); end
      // SOP while discarding restarts a frame.
      beat(1, 1, 0); repeat (4) beat(1, 0, 0);
      beat(1, 1, 0);
      nChecks++; if (eSop4 !== 1'b1 || inF4 !== 1'b1) begin nFail++; $display("FAIL discard_sop got err=%b inF=%b want 1 1", eSop4, inF4); end
      beat(1, 0, 1);
      nChecks++; if (lenV4 !== 1'b1 || len4 !== 3'd2 || fc4 !== 2'd3) begin nFail++; $display("FAIL discard_restart got lenV=%b len=%0d fc=%0d want 1 2 3", lenV4, len4, fc4); end
      beat(1, 1, 1);
      nChecks++; if (fc4 !== 2'd0 || lenV4 !== 1'b1) begin nFail++; $display("FAIL count_wrap got fc=%0d lenV=%b want 0 1", fc4, lenV4); end
   endtask

   task automatic test_reset_mid_frame();
      doReset();
      beat(1, 1, 1); beat(1, 1, 0); beat(1, 0, 0);
      #2 arst = 0;
      #1;
      nChecks++; if (inF !== 1'b0 || fc !== 16'd0 || len !== 11'd0) begin nFail++; $display("FAIL mid_reset got inF=%b fc=%0d len=%0d want 0 0 0", inF, fc, len); end
      @(negedge clk); arst = 1;
      beat(0, 1, 1); beat(0, 0, 1); beat(0, 1, 0);
      nChecks++; if (inF !== 1'b0 || lenV !== 1'b0 || eEop !== 1'b0 || eSop !== 1'b0) begin nFail++; $display("FAIL invalid_ignored got inF=%b lenV=%b eEop=%b eSop=%b want 0", inF, lenV, eEop, eSop); end
      beat(1, 1, 0); beat(0, 1, 1);
      nChecks++; if (inF !== 1'b1 || lenV !== 1'b0 || eSop !== 1'b0) begin nFail++; $display("FAIL invalid_in_frame got inF=%b lenV=%b eSop=%b want 1 0 0", inF, lenV, eSop); end
      beat(1, 0, 1);
      nChecks++; if (lenV !== 1'b1 || len !== 11'd2 || fc !== 16'd1) begin nFail++; $display("FAIL post_reset got lenV=%b len=%0d fc=%0d want 1 2 1", lenV, len, fc); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_single_beat();
      test_eop_no_sop();
      test_sop_in_frame();
      test_too_long();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no completion want finish");
      $fatal(1);
   end
endmodule
